// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the UART transmit path.
// Serialiser state encoding, parity modes and a width helper.
package uart_tx_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Bits needed to hold 0..v-1, never less than one.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered flags and count.
// Writes into a full FIFO are dropped and flagged for one cycle.
module sync_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_nxt;
   logic             wr_ok;
   logic             rd_ok;

   // Space is judged on the registered flag, so a pop never frees a slot
   // for a write in the same cycle.
   assign wr_ok    = push && !full;
   assign rd_ok    = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Occupancy after this cycle's accepted push and pop.
   always_comb begin
      count_nxt = count;
      unique case ({wr_ok, rd_ok})
         2'b10:   count_nxt = count + (AW+1)'(1);
         2'b01:   count_nxt = count - (AW+1)'(1);
         default: count_nxt = count;
      endcase
   end

   // Storage array; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers, count, flags and the overflow pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         count    <= count_nxt;
         full     <= (count_nxt == (AW+1)'(DEPTH));
         empty    <= (count_nxt == '0);
         overflow <= push && full;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO; configurable frame format.
// Frames run back to back while words are queued.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_BITS-1:0]          wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          tx,
   output logic                          busy
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
   localparam int CW       = clog2(STOP_LEN);
   localparam int BW       = clog2(DATA_BITS);

   tx_state_e            state;
   tx_state_e            state_nxt;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cnt_nxt;
   logic [BW-1:0]        bit_idx;
   logic [BW-1:0]        bit_idx_nxt;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_nxt;
   logic [DATA_BITS-1:0] fifo_q;
   logic                 par;
   logic                 par_nxt;
   logic                 tx_nxt;
   logic                 pop;
   logic                 bit_end;
   logic                 stop_end;

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop),
      .pop_data  (fifo_q),
      .full      (full),
      .empty     (empty),
      .count     (fifo_count),
      .overflow  (overflow)
   );

   assign bit_end  = (cnt == CW'(BAUD_DIV - 1));
   assign stop_end = (cnt == CW'(STOP_LEN - 1));
   assign busy     = (state != ST_IDLE);

   // Next-state, line level and word load for the serialiser.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + CW'(1);
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      par_nxt     = par;
      tx_nxt      = tx;
      pop         = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            tx_nxt  = 1'b1;
            pop     = !empty;
         end
         ST_START: begin
            if (bit_end) begin
               state_nxt   = ST_DATA;
               cnt_nxt     = '0;
               tx_nxt      = shift[0];
               shift_nxt   = shift >> 1;
               bit_idx_nxt = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_nxt = '0;
               if (bit_idx == BW'(DATA_BITS - 1)) begin
                  if (PARITY != PARITY_NONE) begin
                     state_nxt = ST_PARITY;
                     tx_nxt    = par;
                  end else begin
                     state_nxt = ST_STOP;
                     tx_nxt    = 1'b1;
                  end
               end else begin
                  tx_nxt      = shift[0];
                  shift_nxt   = shift >> 1;
                  bit_idx_nxt = bit_idx + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_nxt = ST_STOP;
               cnt_nxt   = '0;
               tx_nxt    = 1'b1;
            end
         end
         ST_STOP: begin
            if (stop_end) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               tx_nxt    = 1'b1;
               pop       = !empty;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            tx_nxt    = 1'b1;
         end
      endcase
      // A pop always starts a new frame, from IDLE or straight out of STOP.
      if (pop) begin
         state_nxt = ST_START;
         cnt_nxt   = '0;
         tx_nxt    = 1'b0;
         shift_nxt = fifo_q;
         par_nxt   = (PARITY == PARITY_EVEN) ? ^fifo_q : ~^fifo_q;
      end
   end

   // Serialiser state; reset drops any frame and idles the line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         par     <= 1'b0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
         par     <= par_nxt;
         tx      <= tx_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo across five frame/FIFO configurations.
// Expected line bits are queued at write time and popped per bit.
module tb_uart_tx_fifo;

   function automatic int db_of(input int g);
      return (g == 4) ? 7 : 8;
   endfunction
   function automatic int par_of(input int g);
      return (g == 1) ? 2 : (g == 2) ? 1 : 0;
   endfunction
   function automatic int sb_of(input int g);
      return (g == 4) ? 2 : 1;
   endfunction
   function automatic int fd_of(input int g);
      return (g == 3) ? 4 : 16;
   endfunction

   logic       clk;
   logic       rst;
   logic       wr_en   [5];
   logic [7:0] wr_data [5];
   logic       full    [5];
   logic       empty   [5];
   logic       ovf     [5];
   logic       tx      [5];
   logic       busy    [5];
   logic [4:0] fcnt    [5];

   int vec;
   int errs;
   logic exp_q [$];

   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam int DB = db_of(g);
      localparam int FD = fd_of(g);
      logic [$clog2(FD):0] fc;
      uart_tx_fifo #(
         .CLK_FREQ   (1_000_000),
         .BAUD_RATE  (100_000),
         .DATA_BITS  (DB),
         .PARITY     (par_of(g)),
         .STOP_BITS  (sb_of(g)),
         .FIFO_DEPTH (FD)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .wr_en      (wr_en[g]),
         .wr_data    (wr_data[g][DB-1:0]),
         .full       (full[g]),
         .empty      (empty[g]),
         .fifo_count (fc),
         .overflow   (ovf[g]),
         .tx         (tx[g]),
         .busy       (busy[g])
      );
      assign fcnt[g] = 5'(fc);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_frame(input int g, input logic [7:0] d);
      logic [7:0] m;
      logic       p;
      m = d & ((8'd1 << db_of(g)) - 8'd1);
      exp_q.push_back(1'b0);
      for (int i = 0; i < db_of(g); i++) exp_q.push_back(m[i]);
      p = ^m;
      if (par_of(g) == 2) exp_q.push_back(p);
      else if (par_of(g) == 1) exp_q.push_back(~p);
      for (int i = 0; i < sb_of(g); i++) exp_q.push_back(1'b1);
   endtask

   task automatic wr(input int g, input logic [7:0] d, input bit sent);
      wr_en[g]   = 1'b1;
      wr_data[g] = d;
      if (sent) push_frame(g, d);
      @(negedge clk);
      wr_en[g] = 1'b0;
   endtask

   task automatic check_line(input int g);
      int   w;
      int   nb;
      logic b;
      logic act;
      bit   ok;
      w  = 0;
      nb = 0;
      while (tx[g] !== 1'b0 && w < 60) begin
         @(negedge clk);
         w++;
      end
      vec++;
      if (tx[g] !== 1'b0) begin
         errs++;
         $display("FAIL start_%0d: tx=%b required 0 within 60 cycles", g, tx[g]);
         exp_q.delete();
      end
      while (exp_q.size() > 0) begin
         b   = exp_q.pop_front();
         ok  = 1'b1;
         act = b;
         for (int c = 0; c < 10; c++) begin
            if (tx[g] !== b || busy[g] !== 1'b1) begin
               ok  = 1'b0;
               act = tx[g];
            end
            @(negedge clk);
         end
         vec++;
         if (!ok) begin
            errs++;
            $display("FAIL bit_%0d_%0d: tx=%b busy=%b required tx=%b busy=1",
                     g, nb, act, busy[g], b);
         end
         nb++;
      end
      vec++;
      if (busy[g] !== 1'b0 || tx[g] !== 1'b1) begin
         errs++;
         $display("FAIL idle_%0d: busy=%b tx=%b required busy=0 tx=1",
                  g, busy[g], tx[g]);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         wr_en[g]   = 1'b0;
         wr_data[g] = 8'h00;
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 5; g++) begin
         vec++;
         if (tx[g] !== 1'b1 || busy[g] !== 1'b0 || ovf[g] !== 1'b0) begin
            errs++;
            $display("FAIL rst_line_%0d: tx=%b busy=%b ovf=%b required 1 0 0",
                     g, tx[g], busy[g], ovf[g]);
         end
         vec++;
         if (full[g] !== 1'b0 || empty[g] !== 1'b1 || fcnt[g] !== 5'd0) begin
            errs++;
            $display("FAIL rst_fifo_%0d: full=%b empty=%b count=%0d required 0 1 0",
                     g, full[g], empty[g], fcnt[g]);
         end
      end
   endtask

   task automatic test_8n1;
      fork
         begin
            wr(0, 8'h55, 1'b1);
            vec++;
            if (empty[0] !== 1'b0 || tx[0] !== 1'b1 || fcnt[0] !== 5'd1) begin
               errs++;
               $display("FAIL lat_n1: empty=%b tx=%b count=%0d required 0 1 1",
                        empty[0], tx[0], fcnt[0]);
            end
            @(negedge clk);
            vec++;
            if (tx[0] !== 1'b0 || busy[0] !== 1'b1 || empty[0] !== 1'b1) begin
               errs++;
               $display("FAIL lat_n2: tx=%b busy=%b empty=%b required 0 1 1",
                        tx[0], busy[0], empty[0]);
            end
         end
         check_line(0);
      join
   endtask

   task automatic test_parity;
      logic [7:0] pat [2];
      pat[0] = 8'h07;
      pat[1] = 8'hC3;
      for (int g = 1; g <= 2; g++)
         for (int k = 0; k < 2; k++)
            fork
               wr(g, pat[k], 1'b1);
               check_line(g);
            join
   endtask

   task automatic test_back_to_back;
      logic [7:0] pat [4];
      pat[0] = 8'hA1;
      pat[1] = 8'h3C;
      pat[2] = 8'hFF;
      pat[3] = 8'h00;
      fork
         for (int k = 0; k < 4; k++) wr(0, pat[k], 1'b1);
         check_line(0);
      join
   endtask

   task automatic test_overflow;
      bit ok;
      fork
         begin
            wr(3, 8'h11, 1'b1);
            repeat (5) @(negedge clk);
            for (int k = 1; k <= 4; k++) begin
               wr(3, 8'(8'h20 + k), 1'b1);
               vec++;
               if (fcnt[3] !== 5'(k) || full[3] !== (k == 4)) begin
                  errs++;
                  $display("FAIL fill_%0d: count=%0d full=%b required %0d %b",
                           k, fcnt[3], full[3], k, (k == 4));
               end
            end
            wr(3, 8'hEE, 1'b0);
            vec++;
            if (ovf[3] !== 1'b1 || fcnt[3] !== 5'd4) begin
               errs++;
               $display("FAIL ovf_pulse: ovf=%b count=%0d required 1 4",
                        ovf[3], fcnt[3]);
            end
            @(negedge clk);
            vec++;
            if (ovf[3] !== 1'b0) begin
               errs++;
               $display("FAIL ovf_clear: ovf=%b required 0", ovf[3]);
            end
         end
         check_line(3);
      join
      ok = 1'b1;
      repeat (30) begin
         if (tx[3] !== 1'b1 || busy[3] !== 1'b0 || empty[3] !== 1'b1) ok = 1'b0;
         @(negedge clk);
      end
      vec++;
      if (!ok) begin
         errs++;
         $display("FAIL ovf_dropped: tx=%b busy=%b required dropped word unsent",
                  tx[3], busy[3]);
      end
   endtask

   task automatic test_7n2;
      fork
         wr(4, 8'h7F, 1'b1);
         check_line(4);
      join
      fork
         wr(4, 8'h80, 1'b1);
         check_line(4);
      join
   endtask

   task automatic test_reset_mid;
      bit ok;
      wr(0, 8'hA5, 1'b0);
      wr(0, 8'h3C, 1'b0);
      repeat (45) @(negedge clk);
      vec++;
      if (tx[0] !== 1'b0 || busy[0] !== 1'b1 || empty[0] !== 1'b0) begin
         errs++;
         $display("FAIL pre_rst: tx=%b busy=%b empty=%b required 0 1 0",
                  tx[0], busy[0], empty[0]);
      end
      rst = 1'b0;
      #1;
      vec++;
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 ||
          empty[0] !== 1'b1 || fcnt[0] !== 5'd0) begin
         errs++;
         $display("FAIL mid_rst: tx=%b busy=%b empty=%b count=%0d required 1 0 1 0",
                  tx[0], busy[0], empty[0], fcnt[0]);
      end
      @(negedge clk);
      rst = 1'b1;
      ok  = 1'b1;
      repeat (40) begin
         if (tx[0] !== 1'b1 || busy[0] !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      vec++;
      if (!ok) begin
         errs++;
         $display("FAIL post_rst: tx=%b busy=%b required line idle, no frame",
                  tx[0], busy[0]);
      end
   endtask

   initial begin
      vec  = 0;
      errs = 0;
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_overflow();
      test_7n2();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
